draw_cell_grid: RTL and testbench
=================================

Name: draw_cell_grid

Overview:
- Parametrised successor of the single-square overlay. Paints the whole GRID_N x GRID_N board in one block: owned cells get their player colour, the cursor cell gets a blinking frame, and winning cells flash.
- Sits in the VGA pixel chain after the background/grid renderer and before the cursor/text overlays.
- Forwards all timing signals with a fixed 2-cycle latency.

Parameters:
- GRID_N, 3, cells per row/column (2..4)
- H_ORIGIN, 0, hcount of the board's left edge
- V_ORIGIN, 0, vcount of the board's top edge
- CELL_W, 339, cell width in pixels
- CELL_H, 252, cell height in pixels
- BORDER, 4, cursor frame thickness in pixels (must be < CELL_W/2 and < CELL_H/2)
- BLINK_FRAMES, 30, frames per blink half-period (>= 1)
- COLOR_P0, 12'h00f, player-0 fill colour
- COLOR_P1, 12'hff0, player-1 fill colour
- COLOR_CUR, 12'hf00, cursor frame colour
- COLOR_WIN, 12'hfff, win-flash alternate colour

Ports:
- pclk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- hcount_in  in  11  horizontal pixel counter
- vcount_in  in  11  vertical pixel counter
- hsync_in, vsync_in  in  1 each  sync inputs
- hblnk_in, vblnk_in  in  1 each  blanking inputs
- rgb_in  in  12  upstream pixel colour
- start_en  in  1  game running
- choice_en  in  1  player-choice screen active; suppresses drawing
- cell_occ  in  GRID_N*GRID_N  bit i set: cell i owned (i = row*GRID_N + col)
- cell_owner  in  GRID_N*GRID_N  bit i: owner of cell i (0 = P0, 1 = P1)
- win_mask  in  GRID_N*GRID_N  cells to flash
- cursor_idx  in  4  selected cell index
- cursor_en  in  1  show cursor
- hcount_out, vcount_out  out  11  delayed counters
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  delayed timing
- rgb_out  out  12  composited colour
- blink_phase  out  1  current blink phase (for other overlays)

Behaviour:
- Reset (rst_n low, async assert, sync release): all outputs, pipeline registers, frame counter and blink_phase are cleared to 0.
- Latency: every *_out equals the corresponding *_in delayed by exactly 2 pclk cycles.
- Stage 1 registers:
  - col = largest k < GRID_N with hcount_in >= H_ORIGIN + k*CELL_W; row likewise for vcount.
  - in_board = hcount_in in [H_ORIGIN, H_ORIGIN + GRID_N*CELL_W - 1] and vcount_in in [V_ORIGIN, V_ORIGIN + GRID_N*CELL_H - 1].
  - Intra-cell offsets dx, dy; the timing signals and rgb_in are also registered.
  - Use subtract/compare only; no divider.
- Stage 2 colour priority (highest first):
  1. Pass rgb when !(start_en && !choice_en), or hblnk/vblnk is set, or !in_board.
  2. Cursor frame: cursor_en, idx == cursor_idx, blink_phase = 1, and the pixel is within BORDER of any cell edge -> COLOR_CUR.
  3. Owned cell: cell_occ[idx] set. If win_mask[idx] is set and blink_phase = 1 -> COLOR_WIN; otherwise the owner colour.
  4. Otherwise pass rgb.
- start_en and choice_en are sampled in stage 1 so the control path stays aligned with the pixel.
- Blink counter: frame_cnt increments on each vsync_in rising edge, detected from the stage-1 registered copy.
  - On reaching BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
  - Width is clog2(BLINK_FRAMES), minimum 1.
- cursor_idx >= GRID_N*GRID_N: no cursor is drawn.
- win_mask bits on unowned cells are ignored.
- Board extending past the visible area: pixels are simply never reached; no wrap.
- Pixel exactly on a cell boundary (hcount = H_ORIGIN + k*CELL_W) belongs to column k.
- Mid-frame reset: frame_cnt restarts at 0 and phase at 0; the pipeline refills within 2 cycles.

Decomposition:
- Package draw_pkg holds:
  - 12-bit colour constants (BLUE, YELLOW, RED, WHITE)
  - the cell-index width function
  - default cell geometry for 1024x768
- One natural sub-module, blink_gen: vsync edge detect, frame counter and phase output. It is reusable by other overlays.

Test Plan:
- Reset: hold rst_n = 0 for 5 cycles with random inputs -> all outputs 0; after release, rgb_out tracks rgb_in delayed by 2 cycles.
- Defaults, cell_occ = 9'b000010000, cell_owner = 0, start_en = 1, choice_en = 0:
  - pixel (500,380) -> rgb_out = 12'h00f two cycles later
  - pixel (338,251) -> rgb_in (cell 0 unowned)
  - pixel (339,252) -> 12'h00f
- choice_en = 1, or hblnk_in = 1, with all cells owned -> rgb_out = rgb_in.
- Cursor: cursor_idx = 8, cursor_en = 1, forced phase 1:
  - (678+2, 504+100) -> 12'hf00
  - (678+10, 504+100) -> rgb_in or the owner colour
  - cursor_idx = 12 -> no frame anywhere
- Blink with BLINK_FRAMES = 2: pulse vsync 6 times -> blink_phase sequence 0,1,1,0,0,1 after each pulse; win cell 4 alternates 12'hfff and its owner colour in step.
- Mid-frame reset during active video -> counters cleared, outputs 0 while rst_n is low, correct colours two cycles after release.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared constants and helpers for the board-drawing overlays.
package draw_pkg;

  typedef logic [11:0] rgb_t;

  // 12-bit RGB444 colours
  localparam rgb_t BLUE   = 12'h00f;
  localparam rgb_t YELLOW = 12'hff0;
  localparam rgb_t RED    = 12'hf00;
  localparam rgb_t WHITE  = 12'hfff;

  // Default geometry: a 3x3 board filling a 1024x768 screen
  localparam int DEF_GRID_N = 3;
  localparam int DEF_CELL_W = 339;
  localparam int DEF_CELL_H = 252;

  // ceil(log2(n)) but never less than one bit
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bits needed to index every cell of a grid_n x grid_n board
  function automatic int cell_idx_w(input int grid_n);
    return clog2_min1(grid_n * grid_n);
  endfunction

endpackage

// File: rtl/blink_gen.sv
// Frame-based blink generator: counts vsync rising edges and toggles a
// phase bit every BLINK_FRAMES frames. Reusable by any overlay.
module blink_gen
  import draw_pkg::*;
#(
  parameter int BLINK_FRAMES = 30
) (
  input  logic pclk,
  input  logic rst_n,
  input  logic vsync,
  output logic blink_phase
);

  localparam int CNT_W = clog2_min1(BLINK_FRAMES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLINK_FRAMES - 1);

  logic             r_vsync_d;
  logic [CNT_W-1:0] r_frame_cnt;
  logic             r_phase;
  logic             w_vs_rise;

  assign w_vs_rise   = vsync & ~r_vsync_d;
  assign blink_phase = r_phase;

  // Count frames on vsync rising edges; wrap and flip phase at the last frame
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync_d   <= 1'b0;
      r_frame_cnt <= '0;
      r_phase     <= 1'b0;
    end else begin
      r_vsync_d <= vsync;
      if (w_vs_rise) begin
        if (r_frame_cnt == LAST) begin
          r_frame_cnt <= '0;
          r_phase     <= ~r_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/draw_cell_grid.sv
// Board overlay: paints owned cells, a blinking cursor frame and flashing
// winning cells over the upstream pixel stream. Two-cycle pipeline:
// stage 1 locates the pixel on the board, stage 2 picks the colour.
module draw_cell_grid
  import draw_pkg::*;
#(
  parameter int          GRID_N       = DEF_GRID_N,
  parameter int          H_ORIGIN     = 0,
  parameter int          V_ORIGIN     = 0,
  parameter int          CELL_W       = DEF_CELL_W,
  parameter int          CELL_H       = DEF_CELL_H,
  parameter int          BORDER       = 4,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] COLOR_P0     = BLUE,
  parameter logic [11:0] COLOR_P1     = YELLOW,
  parameter logic [11:0] COLOR_CUR    = RED,
  parameter logic [11:0] COLOR_WIN    = WHITE
) (
  input  logic                       pclk,
  input  logic                       rst_n,
  input  logic [10:0]                hcount_in,
  input  logic [10:0]                vcount_in,
  input  logic                       hsync_in,
  input  logic                       vsync_in,
  input  logic                       hblnk_in,
  input  logic                       vblnk_in,
  input  logic [11:0]                rgb_in,
  input  logic                       start_en,
  input  logic                       choice_en,
  input  logic [GRID_N*GRID_N-1:0]   cell_occ,
  input  logic [GRID_N*GRID_N-1:0]   cell_owner,
  input  logic [GRID_N*GRID_N-1:0]   win_mask,
  input  logic [3:0]                 cursor_idx,
  input  logic                       cursor_en,
  output logic [10:0]                hcount_out,
  output logic [10:0]                vcount_out,
  output logic                       hsync_out,
  output logic                       vsync_out,
  output logic                       hblnk_out,
  output logic                       vblnk_out,
  output logic [11:0]                rgb_out,
  output logic                       blink_phase
);

  localparam int IDX_W = cell_idx_w(GRID_N);

  // ---------------- stage 1: locate pixel on the board ----------------
  logic [1:0]  w_col, w_row;
  logic [10:0] w_col_org, w_row_org;
  logic        w_in_board;

  logic [1:0]  r1_col, r1_row;
  logic [10:0] r1_dx, r1_dy;
  logic        r1_in_board;
  logic [10:0] r1_hcount, r1_vcount;
  logic        r1_hsync, r1_vsync, r1_hblnk, r1_vblnk;
  logic [11:0] r1_rgb;
  logic        r1_start, r1_choice;

  // Column = last cell whose left edge is at or before hcount (compare chain, no divide)
  always_comb begin
    w_col     = '0;
    w_col_org = 11'(H_ORIGIN);
    for (int k = 1; k < GRID_N; k++) begin
      if (int'(hcount_in) >= H_ORIGIN + k * CELL_W) begin
        w_col     = 2'(k);
        w_col_org = 11'(H_ORIGIN + k * CELL_W);
      end
    end
  end

  // Row = last cell whose top edge is at or before vcount
  always_comb begin
    w_row     = '0;
    w_row_org = 11'(V_ORIGIN);
    for (int k = 1; k < GRID_N; k++) begin
      if (int'(vcount_in) >= V_ORIGIN + k * CELL_H) begin
        w_row     = 2'(k);
        w_row_org = 11'(V_ORIGIN + k * CELL_H);
      end
    end
  end

  assign w_in_board = (int'(hcount_in) >= H_ORIGIN) &&
                      (int'(hcount_in) <  H_ORIGIN + GRID_N * CELL_W) &&
                      (int'(vcount_in) >= V_ORIGIN) &&
                      (int'(vcount_in) <  V_ORIGIN + GRID_N * CELL_H);

  // Register cell position, intra-cell offsets, timing and control
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r1_col      <= '0;
      r1_row      <= '0;
      r1_dx       <= '0;
      r1_dy       <= '0;
      r1_in_board <= 1'b0;
      r1_hcount   <= '0;
      r1_vcount   <= '0;
      r1_hsync    <= 1'b0;
      r1_vsync    <= 1'b0;
      r1_hblnk    <= 1'b0;
      r1_vblnk    <= 1'b0;
      r1_rgb      <= '0;
      r1_start    <= 1'b0;
      r1_choice   <= 1'b0;
    end else begin
      r1_col      <= w_col;
      r1_row      <= w_row;
      r1_dx       <= hcount_in - w_col_org;
      r1_dy       <= vcount_in - w_row_org;
      r1_in_board <= w_in_board;
      r1_hcount   <= hcount_in;
      r1_vcount   <= vcount_in;
      r1_hsync    <= hsync_in;
      r1_vsync    <= vsync_in;
      r1_hblnk    <= hblnk_in;
      r1_vblnk    <= vblnk_in;
      r1_rgb      <= rgb_in;
      r1_start    <= start_en;
      r1_choice   <= choice_en;
    end
  end

  // ---------------- blink phase from the registered vsync ----------------
  logic w_phase;

  blink_gen #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .pclk       (pclk),
    .rst_n      (rst_n),
    .vsync      (r1_vsync),
    .blink_phase(w_phase)
  );

  assign blink_phase = w_phase;

  // ---------------- stage 2: colour selection ----------------
  logic [IDX_W-1:0] w_idx;
  logic             w_active, w_on_frame, w_is_cursor;
  logic [11:0]      w_rgb;

  // Cell index never reaches GRID_N*GRID_N, so an out-of-range cursor_idx never matches
  assign w_idx       = IDX_W'(int'(r1_row) * GRID_N + int'(r1_col));
  assign w_active    = r1_start && !r1_choice && !r1_hblnk && !r1_vblnk && r1_in_board;
  assign w_on_frame  = (r1_dx < 11'(BORDER)) || (r1_dx >= 11'(CELL_W - BORDER)) ||
                       (r1_dy < 11'(BORDER)) || (r1_dy >= 11'(CELL_H - BORDER));
  assign w_is_cursor = cursor_en && (int'(cursor_idx) == int'(w_idx)) && w_phase && w_on_frame;

  // Priority: pass-through, cursor frame, owned/winning cell, pass-through
  always_comb begin
    w_rgb = r1_rgb;
    if (w_active) begin
      if (w_is_cursor) begin
        w_rgb = COLOR_CUR;
      end else if (cell_occ[w_idx]) begin
        if (win_mask[w_idx] && w_phase) w_rgb = COLOR_WIN;
        else if (cell_owner[w_idx])     w_rgb = COLOR_P1;
        else                            w_rgb = COLOR_P0;
      end
    end
  end

  // Output registers: composited colour plus timing delayed a second cycle
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= r1_hcount;
      vcount_out <= r1_vcount;
      hsync_out  <= r1_hsync;
      vsync_out  <= r1_vsync;
      hblnk_out  <= r1_hblnk;
      vblnk_out  <= r1_vblnk;
      rgb_out    <= w_rgb;
    end
  end

endmodule

// File: tb/tb_draw_cell_grid.sv
// Bench for draw_cell_grid: directed and random pixels checked against a
// divide/modulo reference of the board layout, two cycles behind.
module tb_draw_cell_grid;

  localparam int N  = 3;
  localparam int CW = 339;
  localparam int CH = 252;
  localparam int B  = 4;
  localparam int BF = 2;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b1;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic        start_en = 1'b0, choice_en = 1'b0;
  logic [8:0]  cell_occ = '0, cell_owner = '0, win_mask = '0;
  logic [3:0]  cursor_idx = '0;
  logic        cursor_en = 1'b0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;
  logic        blink_phase;

  always #5 pclk = ~pclk;

  draw_cell_grid #(
    .BLINK_FRAMES(BF)
  ) dut (
    .pclk(pclk), .rst_n(rst_n),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .start_en(start_en), .choice_en(choice_en),
    .cell_occ(cell_occ), .cell_owner(cell_owner), .win_mask(win_mask),
    .cursor_idx(cursor_idx), .cursor_en(cursor_en),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .blink_phase(blink_phase)
  );

  typedef struct packed {
    logic [11:0] rgb;
    logic [10:0] h;
    logic [10:0] v;
    logic        hs, vs, hb, vb;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   pulses = 0;

  // Reference colour from board arithmetic
  function automatic logic [11:0] model(int h, int v, logic [11:0] rgb,
                                        logic st, logic ch, logic hb, logic vb, logic ph);
    int col, row, idx, dx, dy;
    if (!(st && !ch) || hb || vb) return rgb;
    if (h >= N * CW || v >= N * CH) return rgb;
    col = h / CW;  row = v / CH;
    dx  = h % CW;  dy  = v % CH;
    idx = row * N + col;
    if (cursor_en && int'(cursor_idx) == idx && ph &&
        (dx < B || dx >= CW - B || dy < B || dy >= CH - B))
      return 12'hf00;
    if (cell_occ[idx]) begin
      if (win_mask[idx] && ph) return 12'hfff;
      return cell_owner[idx] ? 12'hff0 : 12'h00f;
    end
    return rgb;
  endfunction

  // One pixel per clock: check the pixel from two clocks ago, then drive a new one
  task automatic step(input int h, input int v, input logic st, input logic ch,
                      input logic hb, input logic vb, input logic vs);
    exp_t e;
    logic [11:0] r;
    logic ph;
    @(negedge pclk);
    if (q.size() == 2) begin
      e = q.pop_front();
      total++;
      assert (rgb_out === e.rgb) else begin
        bad++;
        $error("FAIL rgb h=%0d v=%0d got=%h exp=%h", e.h, e.v, rgb_out, e.rgb);
      end
      total++;
      assert ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} ===
              {e.h, e.v, e.hs, e.vs, e.hb, e.vb}) else begin
        bad++;
        $error("FAIL timing got=%h/%h/%b%b%b%b exp=%h/%h/%b%b%b%b",
               hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
               e.h, e.v, e.hs, e.vs, e.hb, e.vb);
      end
    end
    r = 12'($urandom);
    hcount_in = 11'(h);  vcount_in = 11'(v);
    hsync_in  = 1'($urandom); vsync_in = vs;
    hblnk_in  = hb;  vblnk_in = vb;
    rgb_in    = r;   start_en = st;  choice_en = ch;
    ph = ((pulses / BF) % 2) == 1;
    e.rgb = model(h, v, r, st, ch, hb, vb, ph);
    e.h = 11'(h); e.v = 11'(v); e.hs = hsync_in; e.vs = vs; e.hb = hb; e.vb = vb;
    q.push_back(e);
    $display("pix h=%0d v=%0d rgb_in=%h exp=%h", h, v, r, e.rgb);
  endtask

  task automatic vis(input int h, input int v);
    step(h, v, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Blanked pixels flush the pipe so game-state inputs can change safely
  task automatic drain();
    repeat (2) step(0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic vpulse(input logic exp_ph);
    step(0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (3) step(0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    pulses++;
    total++;
    assert (blink_phase === exp_ph) else begin
      bad++;
      $error("FAIL blink pulse=%0d got=%b exp=%b", pulses, blink_phase, exp_ph);
    end
    $display("vsync pulse %0d blink_phase=%b", pulses, blink_phase);
  endtask

  // Reset held for n cycles with random pixel inputs; everything must read zero
  task automatic hold_reset(input int n);
    repeat (n) begin
      @(negedge pclk);
      total++;
      assert ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
               rgb_out, blink_phase} === '0) else begin
        bad++;
        $error("FAIL reset_out got h=%h v=%h rgb=%h ph=%b", hcount_out, vcount_out,
               rgb_out, blink_phase);
      end
      hcount_in = 11'($urandom); vcount_in = 11'($urandom);
      hsync_in = 1'($urandom); vsync_in = 1'($urandom);
      hblnk_in = 1'($urandom); vblnk_in = 1'($urandom);
      rgb_in = 12'($urandom); start_en = 1'($urandom); choice_en = 1'($urandom);
    end
    vsync_in = 1'b0; hblnk_in = 1'b1;
    q.delete();
    pulses = 0;
    rst_n = 1'b1;
    $display("reset released");
  endtask

  initial begin
    #1 rst_n = 1'b0;
    hold_reset(5);

    // Pass-through with game not running
    repeat (8) step($urandom_range(0, 1100), $urandom_range(0, 800), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Centre cell owned by P0
    drain();
    cell_occ = 9'b000010000; cell_owner = '0; win_mask = '0; cursor_en = 1'b0;
    vis(500, 380);
    vis(338, 251);
    vis(339, 252);
    vis(677, 503);
    vis(678, 504);
    vis(1016, 755);
    vis(1017, 755);
    vis(1016, 756);

    // Drawing suppressed by choice screen or blanking
    drain();
    cell_occ = 9'h1ff; cell_owner = 9'h0a5;
    for (int i = 0; i < 6; i++) begin
      step($urandom_range(0, 1016), $urandom_range(0, 755), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step($urandom_range(0, 1016), $urandom_range(0, 755), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      step($urandom_range(0, 1016), $urandom_range(0, 755), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      vis($urandom_range(0, 1016), $urandom_range(0, 755));
    end

    // Mid-frame reset during active video
    vis(400, 300);
    vis(401, 300);
    @(negedge pclk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    assert ({hcount_out, vcount_out, rgb_out, blink_phase} === '0) else begin
      bad++;
      $error("FAIL async_reset got h=%h v=%h rgb=%h", hcount_out, vcount_out, rgb_out);
    end
    hold_reset(3);
    vis(500, 380);
    vis(100, 100);
    vis(900, 700);
    vis(200, 600);

    // Blink: winning centre cell owned by P1, stray win bits elsewhere
    drain();
    cell_occ = 9'b000010000; cell_owner = 9'b000010000; win_mask = 9'h1ff;
    vpulse(1'b0); vis(500, 380); vis(100, 100);
    vpulse(1'b1); vis(500, 380); vis(100, 100);
    vpulse(1'b1); vis(500, 380); vis(100, 100);
    vpulse(1'b0); vis(500, 380); vis(100, 100);
    vpulse(1'b0); vis(500, 380); vis(100, 100);
    vpulse(1'b1); vis(500, 380); vis(100, 100);

    // Cursor frame on cell 8 with phase 1
    drain();
    cell_occ = 9'h1ff; cell_owner = 9'h155; win_mask = '0;
    cursor_idx = 4'd8; cursor_en = 1'b1;
    vis(680, 604); vis(688, 604); vis(678, 504); vis(681, 604);
    vis(682, 604); vis(1016, 755); vis(1013, 700); vis(1012, 700);
    vis(800, 507); vis(800, 508); vis(800, 752); vis(800, 751);
    vis(677, 604);
    drain();
    cursor_idx = 4'd12;
    vis(680, 604); vis(678, 504); vis(2, 2); vis(1016, 755);

    // Random game states and pixels
    for (int blk = 0; blk < 8; blk++) begin
      drain();
      cell_occ = 9'($urandom); cell_owner = 9'($urandom); win_mask = 9'($urandom);
      cursor_idx = 4'($urandom); cursor_en = 1'($urandom);
      if (blk % 3 == 2) vpulse(((pulses + 1) / BF) % 2 == 1);
      for (int i = 0; i < 40; i++) begin
        step($urandom_range(0, 1100), $urandom_range(0, 800),
             ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 1'b0);
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
